// File: rtl/phase_sign_gen_pkg.sv
// Shared encodings and defaults for the N-phase simulated current-sign generator.
package phase_sign_pkg;

  typedef enum logic [1:0] {
    PSG_IDLE = 2'd0,
    PSG_RUN  = 2'd1,
    PSG_HOLD = 2'd2
  } psg_state_t;

  localparam int         PSG_HALF_60HZ = 416667;
  localparam logic [2:0] PSG_INIT_3PH  = 3'b110;

  // Stagger of phase k: ((nph-k) mod nph) * half / nph, truncated.
  function automatic longint psg_preset(input int nph, input int k, input longint half);
    return (longint'((nph - k) % nph) * half) / longint'(nph);
  endfunction

endpackage

// File: rtl/phase_sign_gen_if.sv
// Control and status bundle of phase_sign_gen; the generator sits on the slave side.
interface phase_sign_gen_if #(
  parameter int NPH = 3,
  parameter int CW  = 19
);
  import phase_sign_pkg::*;

  logic           start_i;
  logic           hold_i;
  logic           step_i;
  logic           load_i;
  logic [CW-1:0]  half_in_i;
  logic [NPH-1:0] sign_o;
  logic [NPH-1:0] sign_valid_o;
  logic [NPH-1:0] edge_o;
  psg_state_t     state_o;
  logic           load_pend_o;

  modport slave (
    input  start_i, hold_i, step_i, load_i, half_in_i,
    output sign_o, sign_valid_o, edge_o, state_o, load_pend_o
  );

  modport master (
    output start_i, hold_i, step_i, load_i, half_in_i,
    input  sign_o, sign_valid_o, edge_o, state_o, load_pend_o
  );

endinterface

// File: rtl/phase_sign_gen_ch.sv
// One phase: wrapping tick counter, sign flip-flop, toggle pulse and dead-zone flag.
module phase_sign_ch #(
  parameter int            CW     = 19,
  parameter logic [CW-1:0] PRESET = '0,
  parameter logic          INIT   = 1'b0,
  parameter logic [CW-1:0] HALF0  = CW'(12),
  parameter logic [CW-1:0] DZ     = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_i,
  input  logic [CW-1:0] half_i,
  input  logic [CW-1:0] half_nxt_i,
  output logic          sign_o,
  output logic          sign_valid_o,
  output logic          edge_o,
  output logic          wrap_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;
  logic          edge_q;
  logic          vld_q, vld_d;

  function automatic logic in_window(input logic [CW-1:0] c, input logic [CW-1:0] h);
    return ($signed({1'b0, c}) >= $signed({1'b0, DZ})) && (c < (h - DZ));
  endfunction

  assign wrap_o = tick_i && (cnt_q >= (half_i - CW'(1)));

  always_comb begin
    cnt_d  = cnt_q;
    sign_d = sign_q;
    if (wrap_o) begin
      cnt_d  = '0;
      sign_d = ~sign_q;
    end else if (tick_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Judged against the half-period that is in force once this tick lands.
  always_comb begin
    vld_d = in_window(cnt_d, half_nxt_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= PRESET;
      sign_q <= INIT;
      edge_q <= 1'b0;
      vld_q  <= in_window(PRESET, HALF0);
    end else begin
      cnt_q  <= cnt_d;
      sign_q <= sign_d;
      edge_q <= wrap_o;
      vld_q  <= vld_d;
    end
  end

  assign sign_o       = sign_q;
  assign sign_valid_o = vld_q;
  assign edge_o       = edge_q;

endmodule

// File: rtl/phase_sign_gen.sv
// N-phase current-sign stimulus source: run/hold/step control and glitch-free half-period reload.
module phase_sign_gen
  import phase_sign_pkg::*;
#(
  parameter int             NPH       = 3,
  parameter int             CW        = 19,
  parameter int             HALF      = PSG_HALF_60HZ,
  parameter int             DZ        = 0,
  parameter logic [NPH-1:0] INIT_SIGN = PSG_INIT_3PH
) (
  input logic               clk,
  input logic               rst,
  phase_sign_gen_if.slave   bus
);

  localparam logic [NPH-1:0] REF_MASK = NPH'(1);

  psg_state_t     state_q, state_d;
  logic [CW-1:0]  half_q, half_d;
  logic [CW-1:0]  pval_q, pval_d;
  logic           pend_q, pend_d;
  logic           tick;
  logic           wrap0;
  logic [NPH-1:0] wrap_w;
  logic [NPH-1:0] sign_w, vld_w, edge_w;

  assign tick  = (state_q == PSG_RUN) || ((state_q == PSG_HOLD) && bus.step_i);
  assign wrap0 = (wrap_w & REF_MASK) != '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      PSG_IDLE: if (bus.start_i) state_d = PSG_RUN;
      PSG_RUN: begin
        if (bus.hold_i)        state_d = PSG_HOLD;
        else if (!bus.start_i) state_d = PSG_IDLE;
      end
      PSG_HOLD: if (!bus.hold_i) state_d = bus.start_i ? PSG_RUN : PSG_IDLE;
      default: state_d = PSG_IDLE;
    endcase
  end

  // A load landing on the wrap tick stays pending for the following wrap.
  always_comb begin
    half_d = half_q;
    pend_d = pend_q;
    pval_d = pval_q;
    if (wrap0 && pend_q) begin
      half_d = pval_q;
      pend_d = 1'b0;
    end
    if (bus.load_i && (bus.half_in_i >= CW'(2))) begin
      pval_d = bus.half_in_i;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PSG_IDLE;
      half_q  <= CW'(HALF);
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    pval_q <= pval_d;
  end

  for (genvar k = 0; k < NPH; k++) begin : g_ph
    localparam logic [CW-1:0] PRE = CW'(psg_preset(NPH, k, longint'(HALF)));
    phase_sign_ch #(
      .CW     (CW),
      .PRESET (PRE),
      .INIT   (INIT_SIGN[NPH-1-k]),
      .HALF0  (CW'(HALF)),
      .DZ     (CW'(DZ))
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .tick_i       (tick),
      .half_i       (half_q),
      .half_nxt_i   (half_d),
      .sign_o       (sign_w[NPH-1-k]),
      .sign_valid_o (vld_w[NPH-1-k]),
      .edge_o       (edge_w[NPH-1-k]),
      .wrap_o       (wrap_w[k])
    );
  end

  assign bus.sign_o       = sign_w;
  assign bus.sign_valid_o = vld_w;
  assign bus.edge_o       = edge_w;
  assign bus.state_o      = state_q;
  assign bus.load_pend_o  = pend_q;

endmodule

// File: tb/tb_phase_sign_gen.sv
// Directed bench for phase_sign_gen: two instances (DZ=0 and DZ=2, HALF=12) against a tick-level model.
module tb_phase_sign_gen;
  import phase_sign_pkg::*;

  localparam int NPH = 3;
  localparam int CW  = 19;
  localparam int H0  = 12;

  logic clk = 1'b0;
  logic rst;
  logic cmp_en;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  phase_sign_gen_if #(.NPH(NPH), .CW(CW)) ifa ();
  phase_sign_gen_if #(.NPH(NPH), .CW(CW)) ifb ();

  assign ifb.start_i   = ifa.start_i;
  assign ifb.hold_i    = ifa.hold_i;
  assign ifb.step_i    = ifa.step_i;
  assign ifb.load_i    = ifa.load_i;
  assign ifb.half_in_i = ifa.half_in_i;

  phase_sign_gen #(.NPH(NPH), .CW(CW), .HALF(H0), .DZ(0), .INIT_SIGN(3'b110)) dut0 (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  phase_sign_gen #(.NPH(NPH), .CW(CW), .HALF(H0), .DZ(2), .INIT_SIGN(3'b110)) dut1 (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: phase k counts (PRE[k] + ticks) modulo the active half-period.
  localparam int PRE [NPH] = '{0, 8, 4};
  localparam int SGN [NPH] = '{1, 1, 0};
  int m_cnt [NPH];
  int m_sign[NPH];
  int m_edge[NPH];
  int m_half, m_pend, m_pval, m_st;

  always @(posedge clk) begin
    int tk, w0;
    if (rst) begin
      for (int k = 0; k < NPH; k++) begin
        m_cnt[k] = PRE[k]; m_sign[k] = SGN[k]; m_edge[k] = 0;
      end
      m_half = H0; m_pend = 0; m_st = 0;
    end else begin
      tk = (m_st == 1 || (m_st == 2 && ifa.step_i)) ? 1 : 0;
      w0 = (tk != 0 && m_cnt[0] >= m_half - 1) ? 1 : 0;
      for (int k = 0; k < NPH; k++) begin
        m_edge[k] = 0;
        if (tk != 0) begin
          if (m_cnt[k] >= m_half - 1) begin
            m_cnt[k] = 0; m_sign[k] = 1 - m_sign[k]; m_edge[k] = 1;
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
      if (w0 != 0 && m_pend != 0) begin m_half = m_pval; m_pend = 0; end
      if (ifa.load_i && int'(ifa.half_in_i) >= 2) begin m_pval = int'(ifa.half_in_i); m_pend = 1; end
      case (m_st)
        0: if (ifa.start_i) m_st = 1;
        1: if (ifa.hold_i) m_st = 2; else if (!ifa.start_i) m_st = 0;
        default: if (!ifa.hold_i) m_st = ifa.start_i ? 1 : 0;
      endcase
    end
  end

  function automatic int exp_vld(input int dz);
    int v = 0;
    for (int k = 0; k < NPH; k++)
      if (m_cnt[k] >= dz && m_cnt[k] < m_half - dz) v |= 1 << (NPH - 1 - k);
    return v;
  endfunction

  always @(posedge clk) begin
    int es, ee;
    #1;
    if (cmp_en) begin
      es = 0; ee = 0;
      for (int k = 0; k < NPH; k++) begin
        es |= m_sign[k] << (NPH - 1 - k);
        ee |= m_edge[k] << (NPH - 1 - k);
      end
      chk("m_sign_a", int'(ifa.sign_o), es);
      chk("m_sign_b", int'(ifb.sign_o), es);
      chk("m_edge_a", int'(ifa.edge_o), ee);
      chk("m_edge_b", int'(ifb.edge_o), ee);
      chk("m_state",  int'(ifa.state_o), m_st);
      chk("m_pend",   int'(ifa.load_pend_o), m_pend);
      chk("m_vld_a",  int'(ifa.sign_valid_o), exp_vld(0));
      chk("m_vld_b",  int'(ifb.sign_valid_o), exp_vld(2));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; cmp_en = 1'b0;
    ifa.start_i = 1'b0; ifa.hold_i = 1'b0; ifa.step_i = 1'b0;
    ifa.load_i = 1'b0; ifa.half_in_i = '0;
    cyc(2);
    cmp_en = 1'b1;
    chk("rst_sign",  int'(ifa.sign_o), 6);
    chk("rst_edge",  int'(ifa.edge_o), 0);
    chk("rst_state", int'(ifa.state_o), int'(PSG_IDLE));
    chk("rst_pend",  int'(ifa.load_pend_o), 0);
    chk("rst_vld_a", int'(ifa.sign_valid_o), 7);
    chk("rst_vld_b", int'(ifb.sign_valid_o), 3);

    rst = 1'b0; ifa.start_i = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      case (n)
        1:  chk("run_state", int'(ifa.state_o), 1);
        3:  chk("t3_sign", int'(ifa.sign_o), 6);
        4:  begin
              chk("t4_sign", int'(ifa.sign_o), 4);
              chk("t4_edge", int'(ifa.edge_o), 2);
              chk("t4_vld_b", int'(ifb.sign_valid_o), 5);
            end
        5:  begin
              chk("t5_edge", int'(ifa.edge_o), 0);
              chk("t5_vld_b", int'(ifb.sign_valid_o), 5);
            end
        6:  chk("t6_vld_b", int'(ifb.sign_valid_o), 6);
        8:  begin
              chk("t8_sign", int'(ifa.sign_o), 5);
              chk("t8_edge", int'(ifa.edge_o), 1);
            end
        12: begin
              chk("t12_sign", int'(ifa.sign_o), 1);
              chk("t12_edge", int'(ifa.edge_o), 4);
            end
        24: chk("t24_sign", int'(ifa.sign_o), 6);
        default: ;
      endcase
    end

    @(negedge clk);
    ifa.hold_i = 1'b1;
    cyc(2);
    chk("hold_state", int'(ifa.state_o), 2);
    chk("hold_sign0", int'(ifa.sign_o), 6);
    cyc(20);
    chk("hold_sign20", int'(ifa.sign_o), 6);
    repeat (3) begin
      ifa.step_i = 1'b1; cyc(1);
      ifa.step_i = 1'b0; cyc(1);
    end
    chk("step_sign", int'(ifa.sign_o), 4);

    ifa.hold_i = 1'b0; ifa.start_i = 1'b0;
    cyc(3);
    chk("idle_state", int'(ifa.state_o), 0);
    ifa.step_i = 1'b1; cyc(1);
    ifa.step_i = 1'b0; cyc(3);
    chk("idle_step_sign", int'(ifa.sign_o), 4);

    ifa.start_i = 1'b1;
    cyc(5);
    ifa.load_i = 1'b1; ifa.half_in_i = CW'(6);
    cyc(1);
    ifa.load_i = 1'b0;
    chk("load_pend_set", int'(ifa.load_pend_o), 1);
    w = 0;
    while (!ifa.edge_o[NPH-1] && w < 40) begin cyc(1); w++; end
    chk("wrap0_wait", w, 3);
    chk("load_pend_clr", int'(ifa.load_pend_o), 0);
    w = 0;
    do begin cyc(1); w++; end while (!ifa.edge_o[NPH-1] && w < 40);
    chk("new_half_period", w, 6);

    ifa.load_i = 1'b1; ifa.half_in_i = CW'(1);
    cyc(1);
    ifa.load_i = 1'b0;
    cyc(2);
    chk("load1_ignored", int'(ifa.load_pend_o), 0);

    ifa.load_i = 1'b1; ifa.half_in_i = CW'(10);
    cyc(1);
    ifa.load_i = 1'b0;
    chk("load10_pend", int'(ifa.load_pend_o), 1);
    rst = 1'b1;
    cyc(2);
    chk("rst2_state", int'(ifa.state_o), 0);
    chk("rst2_pend",  int'(ifa.load_pend_o), 0);
    chk("rst2_sign",  int'(ifa.sign_o), 6);
    chk("rst2_vld_b", int'(ifb.sign_valid_o), 3);
    rst = 1'b0;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("rst2_t4_sign", int'(ifa.sign_o), 4);
    cyc(30);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/phase_sign_gen.md
# phase_sign_gen

Parametrised N-phase simulated current-sign generator for bench and board bring-up of the commutation controller. Each phase toggles its sign every HALF ticks, phases are staggered by fixed offsets, and a dead-zone flag marks each zero-crossing neighbourhood where the sign is unreliable. A run/hold/step FSM and a glitch-free runtime half-period reload turn the generator into a controllable stimulus source that feeds `CurrentSign` of the commutation core.

## Interface
- NPH, 3: number of phases, 1..8
- CW, 19: counter width in bits
- HALF, 416667: reset half-period in ticks (50 MHz / 120 Hz); must be at least 2
- DZ, 0: dead-zone half-width in ticks; must be below HALF/2
- INIT_SIGN, 3'b110: per-phase sign after reset; bit NPH-1 is phase 0 (big-endian, A first)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level; enables generation
- hold  in  1  level; freezes counters while high
- step  in  1  one-cycle pulse; advances one tick while in HOLD
- load  in  1  one-cycle pulse; requests a new half-period
- half_in  in  CW  half-period value for `load`; 0 and 1 are ignored
- sign  out  NPH  simulated current signs, phase 0 in the MSB
- sign_valid  out  NPH  1 = outside the dead zone
- edge  out  NPH  one-cycle pulse coinciding with each sign toggle
- state  out  2  FSM state, encoded per the package
- load_pend  out  1  a reload is waiting for the phase-0 wrap

## Operation
- **Per-phase counter `cnt[k]`.**
  - Counts 0..half-1 on each tick.
  - On a tick where `cnt[k] >= half-1`, `cnt[k]` becomes 0 and `sign[k]` inverts.
- **Reset presets.**
  - `cnt[k] = ((NPH-k) mod NPH) * HALF / NPH`, computed at elaboration and truncated. For the defaults: 0, 277778, 138889.
  - `sign = INIT_SIGN`, `half = HALF`.
- **FSM states:** IDLE=0, RUN=1, HOLD=2.
  - IDLE: no ticks. Moves to RUN when `start=1`.
  - RUN: one tick per cycle. Moves to HOLD if `hold=1`. Otherwise moves to IDLE if `start=0`. `hold` has priority.
  - HOLD: a tick occurs only on a cycle with `step=1`. Moves to RUN when `hold=0 & start=1`. Moves to IDLE when `hold=0 & start=0`.
  - Counters and signs are retained across all transitions; only `rst` re-presets them.
- **Reload.**
  - `load` with `half_in >= 2` latches `half_in` into a pending register and sets `load_pend`.
  - A later `load` before the reload is applied overwrites the pending value.
  - The pending value is applied on the tick where phase 0 wraps: from the next cycle `half` takes the new value and `load_pend` clears.
  - Other counters are unaffected. If a counter is `>= half-1` at its next tick, it wraps on that tick.
- **`sign_valid[k]`:** 1 when `DZ <= cnt[k] < half-DZ`. With DZ=0 it is constantly 1.
- **`edge[k]`:** 1 for exactly the cycle in which the new `sign[k]` is first visible.
- **Arithmetic:** unsigned, CW bits, no overflow, because the counter is bounded by `half`.

## Timing
- All outputs are registered.
- Reset values:
  - `sign=INIT_SIGN`
  - `edge=0`
  - `state=IDLE`
  - `load_pend=0`
  - `sign_valid` computed from the preset counters
- Tick to output latency is 1 cycle: `sign`, `edge` and `sign_valid` reflect the updated counter on the cycle after the tick.
- `start` rising to first tick: 1 cycle (IDLE→RUN registers, ticking begins the following cycle).
- Simultaneous events:
  - `load` on the same cycle as a phase-0 wrap: the value becomes pending and is applied at the following wrap, not the current one.
  - `step` outside HOLD: ignored.
  - `rst` mid-operation: overrides everything, including a pending load.
- With HALF=h, each `sign[k]` has a period of exactly 2h ticks in RUN.

## Structure
- Package `phase_sign_pkg` holds:
  - state encodings `PSG_IDLE`, `PSG_RUN`, `PSG_HOLD`
  - the `psg_state_t` typedef
  - default constants `PSG_HALF_60HZ=416667` and `PSG_INIT_3PH=3'b110`
- Sub-module `phase_sign_ch` implements one phase: counter, sign, edge and dead-zone logic.
  - Parameters: preset count, initial sign.
  - Inputs: `tick`, `half`.
  - Instantiated NPH times by a generate loop.
- The top level holds the FSM, the reload register and the output concatenation.

## Test plan
- **Defaults at reset.** NPH=3, HALF=12, DZ=0. After `rst`, `start=1` → first ticks occur 4, 8 and 12 cycles later.
  - Phase 1 toggles first, at the 4th tick.
  - Phase 2 toggles at the 8th tick, phase 0 at the 12th.
  - `sign` goes 110→100→101→001; `edge` is a single-cycle pulse for each toggle.
- **Period check.** In RUN with HALF=12, each sign has a period of 24 cycles. `sign_valid` is constantly 1.
- **Dead zone.** DZ=2, HALF=12 → `sign_valid[k]` is 0 while `cnt[k]` is in {10, 11, 0, 1}, i.e. 2 cycles either side of every edge.
- **Hold and step.**
  - `hold=1` for 20 cycles → no change in `sign` or the counters.
  - 3 `step` pulses → exactly 3 ticks; a toggle that is due happens on the step.
  - `hold=0`, `start=0` → IDLE, values retained.
- **Reload.** `load` with `half_in=6` mid-period.
  - `load_pend=1` until the phase-0 wrap.
  - Thereafter phase 0 has a period of 12 cycles.
  - A counter already ≥5 wraps on its next tick.
  - `half_in=1` is ignored and `load_pend` stays 0.
- **Reset mid-run with a pending load.** `rst` → presets restored, `half=12`, `load_pend=0`, `state=IDLE`.
